// File: rtl/edge_tx_packer.sv
// edge_tx_packer: reads the edge result frame buffer in row-major order,
// thresholds each pixel to one bit, packs 8 pixels per byte (MSB first) and
// streams the bytes over a valid/ready handshake to the UART TX byte port.
// Optional: define EDGE_TX_CHECKSUM_EN to append an XOR checksum byte.
module edge_tx_packer #(
  parameter int unsigned IMG_WIDTH  = 176,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int unsigned PIX_TH     = 128
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_tx_trig,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  edge_fb_re,
  output logic [ADDR_WIDTH-1:0] edge_fb_rAddr,
  input  logic [7:0]            edge_fb_rData,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready
);

  localparam int unsigned TOTAL  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned NBYTES = (TOTAL + 7) / 8;
  localparam int unsigned PW     = $clog2(NBYTES * 8 + 1);
  localparam int unsigned BW     = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_SEND,
`ifdef EDGE_TX_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      slot_q, slot_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [6:0]      shreg_q, shreg_d;
  logic            re_dly_q;
  logic            busy_d, done_d, re_d, valid_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [7:0]      data_d;
  logic            fetch_bit;
  logic [PW-1:0]   nxt_addr;
`ifdef EDGE_TX_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  // Bit for the slot read in the previous cycle; unread (out-of-frame) slots pack as 0
  assign fetch_bit = re_dly_q && ({1'b0, edge_fb_rData} >= 9'(PIX_TH));
  assign nxt_addr  = pix_q + PW'(slot_q) + PW'(1);

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pix_d   = pix_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    busy_d  = busy;
    done_d  = 1'b0;
    re_d    = 1'b0;
    addr_d  = edge_fb_rAddr;
    valid_d = tx_valid;
    data_d  = tx_data;
`ifdef EDGE_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_tx_trig) begin
          state_d = S_FETCH;
          slot_d  = 3'd0;
          pix_d   = '0;
          bcnt_d  = '0;
          busy_d  = 1'b1;
          re_d    = 1'b1;
          addr_d  = '0;
`ifdef EDGE_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_FETCH: begin
        if (slot_q != 3'd0) shreg_d = {shreg_q[5:0], fetch_bit};
        if (slot_q == 3'd7) begin
          state_d = S_LAST;
        end else begin
          slot_d = slot_q + 3'd1;
          re_d   = (nxt_addr < PW'(TOTAL));
          addr_d = ADDR_WIDTH'(nxt_addr);
        end
      end
      S_LAST: begin
        data_d  = {shreg_q, fetch_bit};
        valid_d = 1'b1;
        pix_d   = pix_q + PW'(8);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          valid_d = 1'b0;
          bcnt_d  = bcnt_q + BW'(1);
`ifdef EDGE_TX_CHECKSUM_EN
          csum_d  = csum_q ^ tx_data;
`endif
          if (bcnt_q == BW'(NBYTES - 1)) begin
`ifdef EDGE_TX_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end else begin
            state_d = S_FETCH;
            slot_d  = 3'd0;
            re_d    = (pix_q < PW'(TOTAL));
            addr_d  = ADDR_WIDTH'(pix_q);
          end
        end
      end
`ifdef EDGE_TX_CHECKSUM_EN
      // Present the checksum one cycle after the last payload handshake
      S_CHK: begin
        if (!tx_valid) begin
          valid_d = 1'b1;
          data_d  = csum_q;
        end else if (tx_ready) begin
          valid_d = 1'b0;
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      pix_q         <= '0;
      bcnt_q        <= '0;
      shreg_q       <= '0;
      re_dly_q      <= 1'b0;
      busy          <= 1'b0;
      tx_done       <= 1'b0;
      edge_fb_re    <= 1'b0;
      edge_fb_rAddr <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
`ifdef EDGE_TX_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      pix_q         <= pix_d;
      bcnt_q        <= bcnt_d;
      shreg_q       <= shreg_d;
      re_dly_q      <= edge_fb_re;
      busy          <= busy_d;
      tx_done       <= done_d;
      edge_fb_re    <= re_d;
      edge_fb_rAddr <= addr_d;
      tx_valid      <= valid_d;
      tx_data       <= data_d;
`ifdef EDGE_TX_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

endmodule
